// File: rtl/dmem_resp_pkg.sv
// Shared state encoding and default parameters for the latency responder.
package dmem_resp_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DEPTH  = 256;
  localparam int unsigned DEF_WAIT_W = 4;
  localparam int unsigned DROP_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_resp_ram.sv
// Single-port synchronous RAM with a registered, clearable read output.
module dmem_resp_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic              clr_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage array: written on enable, never reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read register: holds the last read until another read (or clear) occurs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (clr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_latency_responder.sv
// Data-memory responder with programmable wait states and drop counting.
module dmem_latency_responder
  import dmem_resp_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned WAIT_W = DEF_WAIT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Data_req,
  input  logic              Data_rd,
  input  logic [ADDR_W-1:0] Data_addr,
  input  logic [DATA_W-1:0] Data_din,
  input  logic [WAIT_W-1:0] wait_cfg,
  output logic [DATA_W-1:0] Data_dout,
  output logic              complete_data,
  output logic              busy,
  output logic              addr_err,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int unsigned   IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic                rd_q, rd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                complete_q, complete_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic [DROP_W-1:0]   drop_q, drop_d;

  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_rd;
  logic                in_range;
  logic                ram_we, ram_re, ram_clr;

  // Next-state, capture, completion and RAM control decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    din_d      = din_q;
    drop_d     = drop_q;
    complete_d = 1'b0;
    err_d      = 1'b0;
    busy_d     = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_clr    = 1'b0;

    // With zero wait states the RAM is read on the accept edge, so use live inputs.
    sel_addr = (state_q == IDLE) ? Data_addr : addr_q;
    sel_rd   = (state_q == IDLE) ? Data_rd   : rd_q;
    in_range = ({1'b0, sel_addr} < DEPTH_L);

    case (state_q)
      IDLE: begin
        if (Data_req) begin
          rd_d   = Data_rd;
          addr_d = Data_addr;
          din_d  = Data_din;
          if (wait_cfg == '0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = wait_cfg - WAIT_W'(1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (Data_req && (state_q != IDLE) && (drop_q != {DROP_W{1'b1}})) begin
      drop_d = drop_q + DROP_W'(1);
    end

    complete_d = (state_d == RESP);
    err_d      = complete_d && !in_range;
    busy_d     = (state_d != IDLE);
    ram_re     = complete_d && sel_rd && in_range;
    ram_clr    = complete_d && sel_rd && !in_range;
    // Writes commit at the edge closing the response cycle; reset cancels them.
    ram_we     = (state_q == RESP) && !rd_q && in_range && !reset;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      complete_q <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      complete_q <= complete_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
    end
  end

  dmem_resp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk_i   (clock),
    .rst_i   (reset),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .clr_i   (ram_clr),
    .addr_i  (sel_addr[IDX_W-1:0]),
    .wdata_i (din_q),
    .rdata_o (Data_dout)
  );

  assign complete_data = complete_q;
  assign busy          = busy_q;
  assign addr_err      = err_q;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_dmem_latency_responder.sv
// Directed self-checking bench for dmem_latency_responder (default parameters).
module tb_dmem_latency_responder;

  logic        clock;
  logic        reset;
  logic        Data_req;
  logic        Data_rd;
  logic [15:0] Data_addr;
  logic [15:0] Data_din;
  logic [3:0]  wait_cfg;
  logic [15:0] Data_dout;
  logic        complete_data;
  logic        busy;
  logic        addr_err;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;

  dmem_latency_responder #(
    .DATA_W (16),
    .ADDR_W (16),
    .DEPTH  (256),
    .WAIT_W (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .Data_req      (Data_req),
    .Data_rd       (Data_rd),
    .Data_addr     (Data_addr),
    .Data_din      (Data_din),
    .wait_cfg      (wait_cfg),
    .Data_dout     (Data_dout),
    .complete_data (complete_data),
    .busy          (busy),
    .addr_err      (addr_err),
    .drop_cnt      (drop_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Issue one request, then wait (bounded) for its completion pulse.
  task automatic do_req(input logic rd, input logic [15:0] addr, input logic [15:0] din,
                        input logic [3:0] n, output int lat, output logic err,
                        output logic [15:0] dout);
    lat  = -1;
    err  = 1'b0;
    dout = 16'h0;
    @(negedge clock);
    Data_req  = 1'b1;
    Data_rd   = rd;
    Data_addr = addr;
    Data_din  = din;
    wait_cfg  = n;
    @(negedge clock);
    Data_req = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (complete_data === 1'b1) begin
        lat  = k;
        err  = addr_err;
        dout = Data_dout;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    Data_req  = 1'b1;
    Data_rd   = 1'b0;
    Data_addr = 16'd3;
    Data_din  = 16'hDEAD;
    wait_cfg  = 4'd0;
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy_during got=%b exp=0", busy); end
    checks++;
    if (complete_data !== 1'b0) begin errors++; $display("FAIL rst_complete_during got=%b exp=0", complete_data); end
    Data_req = 1'b0;
    reset    = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++;
    if (complete_data !== 1'b0) begin errors++; $display("FAIL rst_complete got=%b exp=0", complete_data); end
    checks++;
    if (addr_err !== 1'b0) begin errors++; $display("FAIL rst_addr_err got=%b exp=0", addr_err); end
    checks++;
    if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rst_drop_cnt got=%0d exp=0", drop_cnt); end
    checks++;
    if (Data_dout !== 16'h0) begin errors++; $display("FAIL rst_dout got=%h exp=0000", Data_dout); end
  endtask

  task automatic test_zero_wait;
    int lat; logic err; logic [15:0] dout;
    do_req(1'b0, 16'd5, 16'h1234, 4'd0, lat, err, dout);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL zw_write_lat got=%0d exp=1", lat); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL zw_write_err got=%b exp=0", err); end
    checks++;
    if (dout !== 16'h0) begin errors++; $display("FAIL zw_write_dout got=%h exp=0000", dout); end
    do_req(1'b1, 16'd5, 16'h0, 4'd0, lat, err, dout);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL zw_read_lat got=%0d exp=1", lat); end
    checks++;
    if (dout !== 16'h1234) begin errors++; $display("FAIL zw_read_dout got=%h exp=1234", dout); end
  endtask

  task automatic test_wait_states;
    @(negedge clock);
    Data_req  = 1'b1;
    Data_rd   = 1'b1;
    Data_addr = 16'd5;
    wait_cfg  = 4'd3;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      if (k == 1) begin
        Data_req = 1'b0;
        wait_cfg = 4'd0;
      end
      checks++;
      if (busy !== (k <= 4)) begin errors++; $display("FAIL ws_busy_c%0d got=%b exp=%b", k, busy, (k <= 4)); end
      checks++;
      if (complete_data !== (k == 4)) begin
        errors++; $display("FAIL ws_complete_c%0d got=%b exp=%b", k, complete_data, (k == 4));
      end
      if (k == 4) begin
        checks++;
        if (Data_dout !== 16'h1234) begin errors++; $display("FAIL ws_dout got=%h exp=1234", Data_dout); end
      end
    end
  endtask

  task automatic test_addr_err;
    int lat; logic err; logic [15:0] dout;
    do_req(1'b0, 16'd0, 16'h5A5A, 4'd0, lat, err, dout);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL ae_w0_err got=%b exp=0", err); end
    do_req(1'b1, 16'h0100, 16'h0, 4'd1, lat, err, dout);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL ae_rd_lat got=%0d exp=2", lat); end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL ae_rd_err got=%b exp=1", err); end
    checks++;
    if (dout !== 16'h0) begin errors++; $display("FAIL ae_rd_dout got=%h exp=0000", dout); end
    do_req(1'b0, 16'h0100, 16'hFFFF, 4'd0, lat, err, dout);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL ae_wr_err got=%b exp=1", err); end
    do_req(1'b1, 16'd0, 16'h0, 4'd0, lat, err, dout);
    checks++;
    if (dout !== 16'h5A5A) begin errors++; $display("FAIL ae_mem0 got=%h exp=5a5a", dout); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL ae_mem0_err got=%b exp=0", err); end
    do_req(1'b0, 16'd9, 16'h7777, 4'd0, lat, err, dout);
    checks++;
    if (dout !== 16'h5A5A) begin errors++; $display("FAIL ae_hold_dout got=%h exp=5a5a", dout); end
  endtask

  task automatic test_back_to_back;
    @(negedge clock);
    Data_req  = 1'b1;
    Data_rd   = 1'b1;
    Data_addr = 16'd5;
    wait_cfg  = 4'd2;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      checks++;
      if (complete_data !== (k == 3 || k == 7 || k == 11)) begin
        errors++; $display("FAIL b2b_complete_c%0d got=%b exp=%b", k, complete_data, (k == 3 || k == 7 || k == 11));
      end
      if (k == 3 || k == 7 || k == 11) begin
        checks++;
        if (Data_dout !== 16'h1234) begin errors++; $display("FAIL b2b_dout_c%0d got=%h exp=1234", k, Data_dout); end
      end
      if (k == 10) Data_req = 1'b0;
    end
    checks++;
    if (drop_cnt !== 8'd7) begin errors++; $display("FAIL b2b_drop got=%0d exp=7", drop_cnt); end
  endtask

  task automatic test_reset_abort;
    int lat; logic err; logic [15:0] dout;
    do_req(1'b0, 16'd7, 16'h0001, 4'd0, lat, err, dout);
    @(negedge clock);
    Data_req  = 1'b1;
    Data_rd   = 1'b0;
    Data_addr = 16'd7;
    Data_din  = 16'hBEEF;
    wait_cfg  = 4'd5;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (k == 1) Data_req = 1'b0;
      checks++;
      if (complete_data !== 1'b0) begin errors++; $display("FAIL ab_complete_c%0d got=%b exp=0", k, complete_data); end
      if (k == 4) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ab_busy got=%b exp=0", busy); end
      end
      if (k == 3) reset = 1'b1;
      if (k == 5) reset = 1'b0;
    end
    checks++;
    if (drop_cnt !== 8'd0) begin errors++; $display("FAIL ab_drop got=%0d exp=0", drop_cnt); end
    do_req(1'b1, 16'd7, 16'h0, 4'd0, lat, err, dout);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL ab_read_lat got=%0d exp=1", lat); end
    checks++;
    if (dout !== 16'h0001) begin errors++; $display("FAIL ab_mem7 got=%h exp=0001", dout); end
  endtask

  task automatic test_drop_saturation;
    @(negedge clock);
    Data_req  = 1'b1;
    Data_rd   = 1'b1;
    Data_addr = 16'd5;
    wait_cfg  = 4'd15;
    for (int k = 1; k <= 330; k++) begin
      @(negedge clock);
      if (k == 100) begin
        checks++;
        if (drop_cnt !== 8'd94) begin errors++; $display("FAIL sat_drop_mid got=%0d exp=94", drop_cnt); end
      end
    end
    Data_req = 1'b0;
    checks++;
    if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_drop got=%0d exp=255", drop_cnt); end
    repeat (20) @(negedge clock);
    checks++;
    if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_drop_hold got=%0d exp=255", drop_cnt); end
  endtask

  initial begin
    Data_req  = 1'b0;
    Data_rd   = 1'b0;
    Data_addr = 16'h0;
    Data_din  = 16'h0;
    wait_cfg  = 4'd0;
    reset     = 1'b1;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_addr_err();
    test_back_to_back();
    test_reset_abort();
    test_drop_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_latency_responder.md
DMEM_LATENCY_RESPONDER -- requirements
Module: dmem_latency_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning data bus width in bits.
REQ-002 SHALL have parameter ADDR_W, default 16, meaning address bus width in bits.
REQ-003 SHALL have parameter DEPTH, default 256, meaning number of storage words; power of two, at most 2**ADDR_W.
REQ-004 SHALL have parameter WAIT_W, default 4, meaning width of the wait-state configuration.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clock, input, 1 bit, meaning the single clock; all logic is rising-edge.
REQ-007 SHALL have port reset, input, 1 bit, meaning synchronous active-high reset.
REQ-008 SHALL have port Data_req, input, 1 bit, meaning request strobe.
REQ-009 SHALL have port Data_rd, input, 1 bit, meaning access type: 1 = read, 0 = write.
REQ-010 SHALL have port Data_addr, input, ADDR_W bits, meaning word address.
REQ-011 SHALL have port Data_din, input, DATA_W bits, meaning write data.
REQ-012 SHALL have port wait_cfg, input, WAIT_W bits, meaning number of wait states N.
REQ-013 SHALL have port Data_dout, output, DATA_W bits, meaning read data.
REQ-014 SHALL have port complete_data, output, 1 bit, meaning one-cycle completion pulse.
REQ-015 SHALL have port busy, output, 1 bit, meaning a request is in flight.
REQ-016 SHALL have port addr_err, output, 1 bit, meaning out-of-range flag, valid with complete_data.
REQ-017 SHALL have port drop_cnt, output, 8 bits, meaning count of requests dropped while busy.

Function
REQ-018 SHALL implement the state machine IDLE -> WAIT -> RESP -> IDLE; busy = (state != IDLE).
REQ-019 SHALL accept a request only in IDLE with Data_req=1, capturing Data_rd, Data_addr, Data_din and wait_cfg at that edge.
REQ-020 SHALL go IDLE->RESP when the captured N=0, else IDLE->WAIT with the counter loaded to N-1.
REQ-021 SHALL decrement the counter in WAIT and go to RESP when it reads 0.
REQ-022 SHALL, for a request accepted in cycle T, assert complete_data for exactly cycle T+1+N; next acceptance is no earlier than T+2+N.
REQ-023 SHALL, on a read, present mem[addr] registered on Data_dout in the RESP cycle and hold it until the next read completes.
REQ-024 SHALL, on a write, update memory at the RESP edge and leave Data_dout unchanged.
REQ-025 SHALL treat Data_addr >= DEPTH as out of range: addr_err=1 in the RESP cycle, reads return 0, writes are discarded.
REQ-026 SHALL ignore wait_cfg changes after acceptance.
REQ-027 SHALL increment drop_cnt, saturating at 255, for every cycle with Data_req=1 while busy=1.
REQ-028 SHALL give read-after-write to the same address, issued as the next request, the newly written data.

Reset
REQ-029 SHALL, while reset=1, force state IDLE, counter 0, Data_dout 0, complete_data 0, addr_err 0, drop_cnt 0.
REQ-030 SHALL abort any in-flight request on reset mid-operation: no completion pulse, no memory write.
REQ-031 SHALL leave memory contents unreset.
REQ-032 SHALL ignore Data_req in a cycle where reset=1.

Structure
REQ-033 SHALL place the state enum (IDLE/WAIT/RESP) and default parameter constants in shared package dmem_resp_pkg.
REQ-034 SHALL place the storage in sub-module dmem_resp_ram: a single-port synchronous RAM, DEPTH x DATA_W, with write enable.

Verification
REQ-035 SHALL cover this scenario: N=0, write 0x1234 to addr 5, then read addr 5 -> complete_data at T+1 each; Data_dout=0x1234.
REQ-036 SHALL cover this scenario: N=3, read addr 5 accepted at cycle 10 -> busy during cycles 11-14, complete_data only at cycle 14.
REQ-037 SHALL cover this scenario: DEPTH=256, read addr 0x0100 -> addr_err=1 with complete_data, Data_dout=0; a following write to 0x0100 leaves mem[0] unchanged.
REQ-038 SHALL cover this scenario: N=2, Data_req held high for 10 cycles -> requests accepted every 4 cycles; drop_cnt increments once per busy cycle with Data_req=1.
REQ-039 SHALL cover this scenario: N=5, write 0xBEEF to addr 7, reset asserted at T+3 -> no complete_data; mem[7] keeps its prior value (previously written 0x0001); drop_cnt=0.
REQ-040 SHALL cover this scenario: 300 requests dropped while busy -> drop_cnt saturates at 255.
